ifid_queue: RTL and testbench

Two-entry instruction queue between the fetch unit and the decode stage. Captures each fetched instruction with its 30-bit word PC and presents them to decode in order over a valid/ready handshake. Absorbs one cycle of decode stall without dropping fetches, supplies the link address for jump-and-link, and drops everything on a control-flow flush. On a bubble it drives a NOP into decode.

---
 rtl/ifid_queue_pkg.sv | 11 +
 rtl/ifq_slot.sv | 30 +++
 rtl/ifid_queue.sv | 99 +++++++++
 tb/tb_ifid_queue.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ifid_queue_pkg.sv
// ifid_queue_pkg: shared constants for the fetch/decode instruction queue.
//   NOP_INSTR   - word driven into decode while the queue is empty
//   PC_WORD_W   - word-address PC width (byte address = {pc, 2'b00})
//   IFQ_DEPTH   - number of queue slots
//   LINK_OFFSET - jump-and-link return offset in words (skips the delay slot)
package ifid_queue_pkg;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          PC_WORD_W   = 30;
  localparam int          IFQ_DEPTH   = 2;
  localparam int          LINK_OFFSET = 2;
endpackage

// File: rtl/ifq_slot.sv
// ifq_slot: one queue entry, a (pc, instr) register with write enable.
//   clock   - rising-edge clock
//   start   - asynchronous active-low clear
//   we      - capture d_instr/d_pc on this edge
//   d_*     - entry to store
//   q_*     - stored entry
module ifq_slot #(
  parameter int PCW = 30,
  parameter int IW  = 32
) (
  input  logic           clock,
  input  logic           start,
  input  logic           we,
  input  logic [IW-1:0]  d_instr,
  input  logic [PCW-1:0] d_pc,
  output logic [IW-1:0]  q_instr,
  output logic [PCW-1:0] q_pc
);

  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      q_instr <= '0;
      q_pc    <= '0;
    end else if (we) begin
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/ifid_queue.sv
// ifid_queue: two-entry in-order instruction queue between fetch and decode.
//   clock, start        - clock, asynchronous active-low reset
//   in_valid/in_ready   - fetch push handshake (in_instr, in_pc)
//   flush               - drop every queued entry
//   out_valid/out_ready - decode pop handshake (out_instr, out_pc, out_link)
//   count               - occupancy 0..2
//   stall_cnt           - saturating count of cycles fetch was refused
// All out_* and in_ready come from registered state only.
module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int PCW  = PC_WORD_W,
  parameter int IW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clock,
  input  logic            start,
  input  logic            in_valid,
  input  logic [IW-1:0]   in_instr,
  input  logic [PCW-1:0]  in_pc,
  output logic            in_ready,
  input  logic            flush,
  output logic            out_valid,
  output logic [IW-1:0]   out_instr,
  output logic [PCW-1:0]  out_pc,
  output logic [PCW-1:0]  out_link,
  input  logic            out_ready,
  output logic [1:0]      count,
  output logic [CNTW-1:0] stall_cnt
);

  logic                           head;
  logic                           tail;
  logic                           push;
  logic                           pop;
  logic [IFQ_DEPTH-1:0]           slot_we;
  logic [IFQ_DEPTH-1:0][IW-1:0]   slot_instr;
  logic [IFQ_DEPTH-1:0][PCW-1:0]  slot_pc;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Empty queue writes at head so the entry is the next head; otherwise the
  // single occupied slot is head and the free one is its neighbour.
  assign tail = (count == 2'd0) ? head : ~head;

  genvar i;
  generate
    for (i = 0; i < IFQ_DEPTH; i++) begin : g_slot
      assign slot_we[i] = push & ~flush & (tail == i[0]);
      ifq_slot #(.PCW(PCW), .IW(IW)) u_slot (
        .clock   (clock),
        .start   (start),
        .we      (slot_we[i]),
        .d_instr (in_instr),
        .d_pc    (in_pc),
        .q_instr (slot_instr[i]),
        .q_pc    (slot_pc[i])
      );
    end
  endgenerate

  // Flush wins over any same-cycle push/pop.
  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      head  <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      head  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (pop) head <= ~head;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Counts refused fetch cycles; flush does not clear it.
  always_ff @(posedge clock or negedge start) begin
    if (!start)
      stall_cnt <= '0;
    else if (in_valid && !in_ready && (stall_cnt != {CNTW{1'b1}}))
      stall_cnt <= stall_cnt + CNTW'(1);
  end

  always_comb begin
    out_instr = IW'(NOP_INSTR);
    out_pc    = '0;
    out_link  = '0;
    if (out_valid) begin
      out_instr = slot_instr[head];
      out_pc    = slot_pc[head];
      out_link  = slot_pc[head] + PCW'(LINK_OFFSET);
    end
  end

endmodule

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: directed test of ifid_queue with hand-computed expectations.
module tb_ifid_queue;

  logic        clock = 1'b0;
  logic        start;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [29:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [29:0] out_pc;
  logic [29:0] out_link;
  logic        out_ready;
  logic [1:0]  count;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ifid_queue dut (
    .clock     (clock),
    .start     (start),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_link  (out_link),
    .out_ready (out_ready),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  function automatic logic [31:0] mk(input logic [29:0] pc);
    return {2'b11, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [29:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = mk(pc);
  endtask

  initial begin
    start = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 30'h0);
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_oval", 64'(out_valid), 64'd0);
    chk("rst_irdy", 64'(in_ready), 64'd1);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_link", 64'(out_link), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    @(negedge clock);
    start = 1'b1;

    // streaming, one per cycle after 1-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 30'h100 + 30'(i));
      tick();
      chk("str_pc", 64'(out_pc), 64'h100 + 64'(i));
      chk("str_instr", 64'(out_instr), 64'(mk(30'h100 + 30'(i))));
      chk("str_count", 64'(count), 64'd1);
      if (i == 0) chk("str_link", 64'(out_link), 64'h102);
    end
    drive(1'b0, 30'h0);
    tick();
    chk("str_empty", 64'(out_valid), 64'd0);
    chk("str_nop", 64'(out_instr), 64'd0);
    chk("str_link0", 64'(out_link), 64'd0);

    // decode stall for three cycles
    out_ready = 1'b0;
    drive(1'b1, 30'h200); tick();
    chk("stl_c1", 64'(count), 64'd1);
    chk("stl_r1", 64'(in_ready), 64'd1);
    drive(1'b1, 30'h201); tick();
    chk("stl_c2", 64'(count), 64'd2);
    chk("stl_r2", 64'(in_ready), 64'd0);
    drive(1'b1, 30'h202); tick();
    chk("stl_cnt", 64'(stall_cnt), 64'd1);
    chk("stl_c3", 64'(count), 64'd2);
    chk("stl_head", 64'(out_pc), 64'h200);
    drive(1'b0, 30'h0); out_ready = 1'b1; tick();
    chk("stl_d1", 64'(out_pc), 64'h201);
    chk("stl_dc1", 64'(count), 64'd1);
    tick();
    chk("stl_d2", 64'(count), 64'd0);

    // flush at full with in_valid and out_ready high
    out_ready = 1'b0;
    drive(1'b1, 30'h300); tick();
    drive(1'b1, 30'h301); tick();
    chk("fl_full", 64'(count), 64'd2);
    drive(1'b1, 30'h302); out_ready = 1'b1; flush = 1'b1; tick();
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_oval", 64'(out_valid), 64'd0);
    chk("fl_instr", 64'(out_instr), 64'd0);
    chk("fl_irdy", 64'(in_ready), 64'd1);
    chk("fl_stall", 64'(stall_cnt), 64'd2);
    flush = 1'b0; drive(1'b0, 30'h0); tick();
    chk("fl_lost", 64'(count), 64'd0);

    // push+pop at count=1 with head on slot 1, tail wraps to slot 0
    out_ready = 1'b0;
    drive(1'b1, 30'h400); tick();
    drive(1'b1, 30'h401); tick();
    drive(1'b0, 30'h0); out_ready = 1'b1; tick();
    chk("pp_h1", 64'(out_pc), 64'h401);
    chk("pp_c1", 64'(count), 64'd1);
    drive(1'b1, 30'h402); tick();
    chk("pp_pc2", 64'(out_pc), 64'h402);
    chk("pp_in2", 64'(out_instr), 64'(mk(30'h402)));
    chk("pp_c2", 64'(count), 64'd1);
    drive(1'b1, 30'h403); tick();
    chk("pp_pc3", 64'(out_pc), 64'h403);
    drive(1'b0, 30'h0); tick();
    chk("pp_empty", 64'(count), 64'd0);

    // link wraps at the top of the PC space
    drive(1'b1, 30'h3FFF_FFFF); tick();
    chk("wr_pc", 64'(out_pc), 64'h3FFF_FFFF);
    chk("wr_link", 64'(out_link), 64'h1);
    drive(1'b0, 30'h0); tick();

    // stall counter saturation
    out_ready = 1'b0;
    drive(1'b1, 30'h500); tick();
    drive(1'b1, 30'h501); tick();
    repeat (65541) tick();
    chk("sat_cnt", 64'(stall_cnt), 64'hFFFF);
    chk("sat_count", 64'(count), 64'd2);
    chk("sat_head", 64'(out_pc), 64'h500);

    // asynchronous reset while full, checked before any edge
    #2;
    start = 1'b0;
    #1;
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_oval", 64'(out_valid), 64'd0);
    chk("ar_instr", 64'(out_instr), 64'd0);
    chk("ar_pc", 64'(out_pc), 64'd0);
    chk("ar_irdy", 64'(in_ready), 64'd1);
    chk("ar_stall", 64'(stall_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
